sap1_controller: RTL



---
 rtl/sap1_pkg.sv | 41 ++++
 rtl/sap1_ring_counter.sv | 44 ++++
 rtl/sap1_controller.sv | 102 ++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, phase indices, control-word layout.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    // Control word is {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}, cp in the MSB.
    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_e;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'b0) && ((v & (v - 6'd1)) == 6'b0);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-phase one-hot ring counter with a sticky halt mode; any non-one-hot ring recovers to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       halt_req,
    output logic [5:0] t_state,
    output logic       halted
);

    localparam logic [5:0] RING_T1 = 6'b000001;

    logic [5:0] ring_q, ring_d;
    mode_e      mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            ring_q <= RING_T1;
            mode_q <= MODE_RUN;
        end else begin
            ring_q <= ring_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        ring_d = ring_q;
        mode_d = mode_q;
        if (mode_q == MODE_RUN) begin
            if (halt_req) begin
                mode_d = MODE_HALT;
            end else if (is_onehot6(ring_q)) begin
                ring_d = {ring_q[4:0], ring_q[5]};
            end else begin
                ring_d = RING_T1;
            end
        end
    end

    assign halted  = (mode_q == MODE_HALT);
    assign t_state = halted ? 6'b0 : ring_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: ring counter plus combinational decode of (phase, opcode) into strobes.
module sap1_controller
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt
);

    logic            halted;
    logic            phase_ok;
    logic            halt_req;
    logic [CW_W-1:0] ctrl;

    sap1_ring_counter u_ring (
        .clk      (clk),
        .clr      (clr),
        .halt_req (halt_req),
        .t_state  (t_state),
        .halted   (halted)
    );

    // An illegal ring decodes to no strobes, which keeps the bus invariant for every ring value.
    assign phase_ok = !clr && !halted && is_onehot6(t_state);
    assign halt_req = phase_ok && t_state[T4] && (opcode == OP_HLT);

    always_comb begin
        ctrl = '0;
        if (phase_ok) begin
            if (t_state[T1]) begin
                ctrl[CW_EP] = 1'b1;
                ctrl[CW_LM] = 1'b1;
            end else if (t_state[T2]) begin
                ctrl[CW_CP] = 1'b1;
            end else if (t_state[T3]) begin
                ctrl[CW_CE] = 1'b1;
                ctrl[CW_LI] = 1'b1;
            end else if (t_state[T4]) begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl[CW_EI] = 1'b1;
                        ctrl[CW_LM] = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl[CW_EA] = 1'b1;
                        ctrl[CW_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end else if (t_state[T5]) begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[CW_CE] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CW_CE] = 1'b1;
                        ctrl[CW_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end else if (t_state[T6]) begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[CW_EU] = 1'b1;
                    ctrl[CW_LA] = 1'b1;
                    ctrl[CW_SU] = (opcode == OP_SUB);
                end
            end
        end
    end

    assign cp  = ctrl[CW_CP];
    assign ep  = ctrl[CW_EP];
    assign lm  = ctrl[CW_LM];
    assign ce  = ctrl[CW_CE];
    assign li  = ctrl[CW_LI];
    assign ei  = ctrl[CW_EI];
    assign la  = ctrl[CW_LA];
    assign ea  = ctrl[CW_EA];
    assign su  = ctrl[CW_SU];
    assign eu  = ctrl[CW_EU];
    assign lb  = ctrl[CW_LB];
    assign lo  = ctrl[CW_LO];
    assign hlt = halted && !clr;

    bus_onehot_a: assert property (@(posedge clk) $onehot0({ep, ce, ei, ea, eu}));

endmodule
